// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio echo stage.
package audio_pkg;

    // Signed sample width per channel
    localparam int DATA_W = 24;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        FETCH,
        CALC,
        SEND
    } state_t;

    // Add two signed samples in one extra bit, then clamp to the sample range.
    // A carry into the guard bit shows up as guard != sign of the narrow result.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            return sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/audio_echo_stage_if.sv
// Codec FIFO handshake: ADC pop side and DAC push side.
interface audio_echo_stage_if #(
    parameter int DATA_W = audio_pkg::DATA_W
);
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;

    // The echo stage drives the pop/push strobes and the processed samples
    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
        output read, write, writedata_left, writedata_right
    );

    // The codec side offers samples and accepts results
    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
        input  read, write, writedata_left, writedata_right
    );
endinterface

// File: rtl/echo_ram.sv
// Delay line storage: simple dual-port, registered read, no reset.
module echo_ram #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/audio_echo_stage.sv
// Feedback echo: out = sat(in + delayed_out >>> ATTEN_SHIFT), one pair per 4 cycles.
module audio_echo_stage
    import audio_pkg::*;
#(
    parameter int DATA_W      = audio_pkg::DATA_W,
    parameter int DEPTH_LOG2  = 12,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                echo_en,
    audio_echo_stage_if.master  codec
);
    state_t                   r_state;
    state_t                   w_state_next;
    logic [DEPTH_LOG2-1:0]    r_ptr;
    logic signed [DATA_W-1:0] r_in   [2];
    logic signed [DATA_W-1:0] r_out  [2];
    logic signed [DATA_W-1:0] w_calc [2];
    logic                     w_read;
    logic                     w_write;
    logic                     w_ram_we;
    logic [2*DATA_W-1:0]      w_ram_wdata;
    logic [2*DATA_W-1:0]      w_ram_rdata;
    logic [2*DATA_W-1:0]      w_ram_out;

    // Channel 0 = left in the low half of the RAM word, channel 1 = right
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic signed [DATA_W-1:0] w_dly;
        logic signed [DATA_W-1:0] w_echo;
        assign w_dly      = w_ram_rdata[gi*DATA_W +: DATA_W];
        assign w_echo     = w_dly >>> ATTEN_SHIFT;
        assign w_calc[gi] = echo_en ? sat_add(r_in[gi], w_echo) : r_in[gi];
        assign w_ram_out[gi*DATA_W +: DATA_W] = r_out[gi];
    end

    // Next state and strobes; reset masks every strobe so a pending SEND never fires
    always_comb begin
        w_state_next = r_state;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_wdata  = '0;
        case (r_state)
            CLEAR: begin
                w_ram_we = 1'b1;
                if (&r_ptr) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (codec.read_ready) begin
                    w_read       = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH: w_state_next = CALC;
            CALC:  w_state_next = SEND;
            SEND: begin
                if (codec.write_ready) begin
                    w_write      = 1'b1;
                    w_ram_we     = 1'b1;
                    w_ram_wdata  = w_ram_out;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = CLEAR;
        endcase
        if (reset) begin
            w_read   = 1'b0;
            w_write  = 1'b0;
            w_ram_we = 1'b0;
        end
    end

    // State, delay pointer, captured input and registered output
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_in[i]  <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR || w_write) begin
                r_ptr <= r_ptr + DEPTH_LOG2'(1);
            end
            if (w_read) begin
                r_in[0] <= codec.readdata_left;
                r_in[1] <= codec.readdata_right;
            end
            if (r_state == CALC) begin
                r_out[0] <= w_calc[0];
                r_out[1] <= w_calc[1];
            end
        end
    end

    // Read address is the oldest sample, which is also the slot overwritten in SEND
    echo_ram #(
        .WIDTH  (2*DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (CLOCK_50),
        .i_we    (w_ram_we),
        .i_waddr (r_ptr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_ptr),
        .o_rdata (w_ram_rdata)
    );

    assign codec.read            = w_read;
    assign codec.write           = w_write;
    assign codec.writedata_left  = r_out[0];
    assign codec.writedata_right = r_out[1];
endmodule

// File: tb/tb_audio_echo_stage.sv
// Directed bench for audio_echo_stage with a 16-sample delay line.
module tb_audio_echo_stage;
    import audio_pkg::*;

    localparam int W = 24;

    logic clk;
    logic reset;
    logic echo_en;
    int   n_checks;
    int   n_pass;

    audio_echo_stage_if bus ();

    audio_echo_stage #(
        .DATA_W      (W),
        .DEPTH_LOG2  (4),
        .ATTEN_SHIFT (1)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .echo_en  (echo_en),
        .codec    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reset and sit out the 16-cycle clear sweep with nothing offered
    task automatic reset_dut();
        bus.read_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // One sample pair through the stage; stall>0 holds write_ready low for that many SEND cycles
    task automatic do_sample(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                             input logic [W-1:0] el, input logic [W-1:0] er, input int stall);
        int lat;
        bit seen;
        @(negedge clk);
        bus.read_ready     = 1'b1;
        bus.readdata_left  = l;
        bus.readdata_right = r;
        bus.write_ready    = (stall == 0);
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            #1;
            if (bus.read) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_read"}, 48'(seen), 48'd1);
        if (!seen) return;
        @(negedge clk);
        lat = 1;
        if (stall == 0) begin
            bus.read_ready = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                #1;
                if (bus.write) seen = 1'b1;
                else begin
                    @(negedge clk);
                    lat++;
                end
            end
            check({tag, "_lat"}, 48'(lat), 48'd3);
        end else begin
            // A fresh pair is on offer the whole time; it must not be popped
            bus.readdata_left  = ~l;
            bus.readdata_right = ~r;
            @(negedge clk);
            @(negedge clk);
            for (int k = 0; k < stall; k++) begin
                #1;
                check({tag, "_hold_write"}, 48'(bus.write), 48'd0);
                check({tag, "_hold_read"}, 48'(bus.read), 48'd0);
                check({tag, "_hold_data"}, {bus.writedata_left, bus.writedata_right}, {el, er});
                @(negedge clk);
            end
            bus.write_ready = 1'b1;
            #1;
            seen = bus.write;
            lat = 3 + stall;
        end
        check({tag, "_write"}, 48'(seen), 48'd1);
        check({tag, "_data"}, {bus.writedata_left, bus.writedata_right}, {el, er});
        $display("sample %s in=%h/%h out=%h/%h lat=%0d", tag, l, r,
                 bus.writedata_left, bus.writedata_right, lat);
        if (stall != 0) begin
            @(negedge clk);
            bus.read_ready = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] rl;
        logic [W-1:0] rr;
        int           k_first;
        bit           any_wr;
        n_checks = 0;
        n_pass   = 0;
        echo_en  = 1'b1;
        reset    = 1'b1;
        bus.read_ready     = 1'b0;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        bus.write_ready    = 1'b1;

        // Reset state, then count clear cycles while a zero pair is already offered
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_read", 48'(bus.read), 48'd0);
        check("rst_write", 48'(bus.write), 48'd0);
        check("rst_data", {bus.writedata_left, bus.writedata_right}, 48'd0);
        reset = 1'b0;
        bus.read_ready = 1'b1;
        k_first = -1;
        any_wr  = 1'b0;
        for (int k = 0; k < 40 && k_first < 0; k++) begin
            if (bus.write) any_wr = 1'b1;
            if (bus.read) k_first = k;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("clear_cycles", 48'(k_first), 48'd16);
        check("clear_no_write", 48'(any_wr), 48'd0);
        @(negedge clk);
        bus.read_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("first_write", 48'(bus.write), 48'd1);
        check("first_data", {bus.writedata_left, bus.writedata_right}, 48'd0);
        do_sample("zero_a", '0, '0, '0, '0, 0);
        do_sample("zero_b", '0, '0, '0, '0, 0);

        // Impulse: echoes at 16 and 32 samples, halved each time
        reset_dut();
        for (int s = 0; s < 40; s++) begin
            exp_v = (s == 0) ? 24'h100000 : (s == 16) ? 24'h080000 :
                    (s == 32) ? 24'h040000 : 24'h000000;
            do_sample($sformatf("imp%0d", s), (s == 0) ? 24'h100000 : 24'h0,
                      (s == 0) ? 24'h100000 : 24'h0, exp_v, exp_v, 0);
        end

        // Reset while SEND waits on write_ready: no pulse, full clear, no echo afterwards
        @(negedge clk);
        bus.read_ready     = 1'b1;
        bus.readdata_left  = 24'h100000;
        bus.readdata_right = 24'h100000;
        bus.write_ready    = 1'b0;
        #1;
        check("rs_read", 48'(bus.read), 48'd1);
        @(negedge clk);
        bus.read_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rs_wait", 48'(bus.write), 48'd0);
        reset = 1'b1;
        bus.write_ready = 1'b1;
        #1;
        check("rs_write_masked", 48'(bus.write), 48'd0);
        @(negedge clk);
        #1;
        check("rs_data", {bus.writedata_left, bus.writedata_right}, 48'd0);
        reset = 1'b0;
        any_wr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus.write || bus.read) any_wr = 1'b1;
            @(negedge clk);
            #1;
        end
        check("rs_clear_quiet", 48'(any_wr), 48'd0);
        for (int s = 0; s < 18; s++) begin
            do_sample($sformatf("post%0d", s), '0, '0, '0, '0, 0);
        end

        // Positive saturation
        reset_dut();
        for (int s = 0; s < 20; s++) begin
            exp_v = (s < 16) ? 24'h7FFFF0 : 24'h7FFFFF;
            do_sample($sformatf("satp%0d", s), 24'h7FFFF0, 24'h7FFFF0, exp_v, exp_v, 0);
        end

        // Negative saturation (-0x7FFFF0 = 0x800010)
        reset_dut();
        for (int s = 0; s < 20; s++) begin
            exp_v = (s < 16) ? 24'h800010 : 24'h800000;
            do_sample($sformatf("satn%0d", s), 24'h800010, 24'h800010, exp_v, exp_v, 0);
        end

        // Pass-through with echo disabled, independent channels
        echo_en = 1'b0;
        for (int s = 0; s < 10; s++) begin
            rl = W'($urandom);
            rr = W'($urandom);
            do_sample($sformatf("pass%0d", s), rl, rr, rl, rr, 0);
        end

        // Back-pressure: 10 cycles in SEND with write_ready low
        do_sample("stall", 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 10);
        do_sample("after_stall", 24'h000042, 24'hFFFFC0, 24'h000042, 24'hFFFFC0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
